updown_mod_counter: RTL



---
 rtl/updown_mod_counter.sv | 106 ++++++++++
 1 files changed

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MOD counter with sync clear, clamped parallel load, wrap-or-saturate
// mode and a combinational carry/borrow (tc). Optional prescaler: COUNTER_PRESCALE_EN.
module updown_mod_counter #(
  parameter int W        = 4,
  parameter int MOD      = 10,
  parameter int PRESCALE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         wrapped
);

  if (MOD < 2 || MOD > (1 << W) || PRESCALE < 2) begin : g_bad_param
    $error("updown_mod_counter: illegal W/MOD/PRESCALE combination");
  end

  // One extra bit so MOD == 2**W and MOD-1 compare without overflow.
  localparam logic [W:0]   MOD_W = (W+1)'(MOD);
  localparam logic [W:0]   MAX_W = (W+1)'(MOD - 1);
  localparam logic [W-1:0] MAX_V = MAX_W[W-1:0];

  logic [W-1:0] count_d, count_q;
  logic         wrapped_d, wrapped_q;
  logic         step_qual;
  logic         at_max, at_zero, at_lim;

`ifdef COUNTER_PRESCALE_EN
  localparam int            PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] ps_d, ps_q;

  assign step_qual = (ps_q == PS_LAST);
`else
  assign step_qual = 1'b1;
`endif

  assign at_max  = ({1'b0, count_q} == MAX_W);
  assign at_zero = (count_q == '0);
  assign at_lim  = up ? at_max : at_zero;

  // Carry/borrow ignores sat so a saturating stage still feeds its successor.
  assign tc = en & step_qual & at_lim;

  always_comb begin
    count_d   = count_q;
    wrapped_d = 1'b0;
`ifdef COUNTER_PRESCALE_EN
    ps_d      = ps_q;
`endif
    if (clr) begin
      count_d = '0;
`ifdef COUNTER_PRESCALE_EN
      ps_d    = '0;
`endif
    end else if (load) begin
      count_d = ({1'b0, load_val} >= MOD_W) ? MAX_V : load_val;
`ifdef COUNTER_PRESCALE_EN
      ps_d    = '0;
`endif
    end else if (en) begin
`ifdef COUNTER_PRESCALE_EN
      ps_d = step_qual ? '0 : ps_q + PW'(1);
`endif
      if (step_qual) begin
        if (at_lim) begin
          if (!sat) begin
            count_d   = up ? '0 : MAX_V;
            wrapped_d = 1'b1;
          end
        end else begin
          count_d = up ? count_q + W'(1) : count_q - W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      wrapped_q <= wrapped_d;
    end
  end

`ifdef COUNTER_PRESCALE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else        ps_q <= ps_d;
  end
`endif

  assign count   = count_q;
  assign wrapped = wrapped_q;

endmodule
